// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned restoring divider for the EX stage (DIV/DIVU).
// Produces {remainder, quotient} after 33 cycles; stalls EX via stop_req while busy.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        signed_div,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        start,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic        stop_req
);

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t      state_reg;
    logic [5:0]  cnt_reg;
    logic [64:0] work_reg;
    logic [31:0] divisor_mag_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic [63:0] result_reg;
    logic        ready_reg;

    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic [32:0] trial;
    logic [31:0] quot_raw;
    logic [31:0] rem_raw;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // 0x80000000 negates to itself and is then read as unsigned 2^31.
    assign dividend_mag = (signed_div && dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign divisor_mag  = (signed_div && divisor[31])  ? (~divisor + 32'd1)  : divisor;

    // Bit 32 set means the partial remainder is smaller than the divisor.
    assign trial = {1'b0, work_reg[63:32]} - {1'b0, divisor_mag_reg};

    assign quot_raw = work_reg[31:0];
    assign rem_raw  = work_reg[64:33];
    assign quot_fix = neg_q_reg ? (~quot_raw + 32'd1) : quot_raw;
    assign rem_fix  = neg_r_reg ? (~rem_raw + 32'd1)  : rem_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_FREE;
            cnt_reg         <= 6'd0;
            work_reg        <= 65'd0;
            divisor_mag_reg <= 32'd0;
            neg_q_reg       <= 1'b0;
            neg_r_reg       <= 1'b0;
            result_reg      <= 64'd0;
            ready_reg       <= 1'b0;
        end else if (annul) begin
            // Flush discards any operation in flight, including one finishing this cycle.
            state_reg  <= S_FREE;
            cnt_reg    <= 6'd0;
            result_reg <= 64'd0;
            ready_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_FREE: begin
                    if (start) begin
                        if (divisor == 32'd0) begin
                            state_reg <= S_BYZERO;
                        end else begin
                            state_reg       <= S_ON;
                            cnt_reg         <= 6'd0;
                            work_reg        <= {32'd0, dividend_mag, 1'b0};
                            divisor_mag_reg <= divisor_mag;
                            neg_q_reg       <= signed_div & (dividend[31] ^ divisor[31]);
                            neg_r_reg       <= signed_div & dividend[31];
                        end
                    end
                end
                S_BYZERO: begin
                    result_reg <= 64'd0;
                    ready_reg  <= 1'b1;
                    state_reg  <= S_END;
                end
                S_ON: begin
                    if (cnt_reg != 6'd32) begin
                        if (trial[32]) begin
                            work_reg <= {work_reg[63:0], 1'b0};
                        end else begin
                            work_reg <= {trial[31:0], work_reg[31:0], 1'b1};
                        end
                        cnt_reg <= cnt_reg + 6'd1;
                    end else begin
                        result_reg <= {rem_fix, quot_fix};
                        ready_reg  <= 1'b1;
                        state_reg  <= S_END;
                    end
                end
                S_END: begin
                    // Hold the result until EX releases start after writing HI/LO.
                    if (!start) begin
                        state_reg  <= S_FREE;
                        result_reg <= 64'd0;
                        ready_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_FREE;
                end
            endcase
        end
    end

    assign result   = result_reg;
    assign ready    = ready_reg;
    assign stop_req = start & ~ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized divisions
// compared against a plain-arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stop_req;

    int total;
    int bad;

    div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stop_req   (stop_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: DIV truncates toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (!sd) return {a % b, a / b};
        ma = a[31] ? (32'd0 - a) : a;
        mb = b[31] ? (32'd0 - b) : b;
        q = ma / mb;
        r = ma % mb;
        if (a[31] != b[31]) q = 32'd0 - q;
        if (a[31]) r = 32'd0 - r;
        return {r, q};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                           input int hold);
        logic [63:0] exp_res;
        int lat;
        int stall_cycles;
        int exp_lat;
        exp_res = model(sd, a, b);
        exp_lat = (b == 32'd0) ? 1 : 33;
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        tick();
        // Operands after the start edge must be ignored.
        dividend   = $urandom;
        divisor    = $urandom;
        signed_div = 1'($urandom);
        lat = 0;
        stall_cycles = 0;
        while (ready !== 1'b1 && lat < 40) begin
            if (stop_req === 1'b1) stall_cycles++;
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("stall_len", 64'(stall_cycles), 64'(exp_lat));
        check("result", result, exp_res);
        check("stop_req_drop", 64'(stop_req), 64'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_ready", 64'(ready), 64'd1);
            check("hold_result", result, exp_res);
        end
        start = 1'b0;
        tick();
        check("release_ready", 64'(ready), 64'd0);
        check("release_result", result, 64'd0);
        $display("div sd=%0d a=%h b=%h result=%h lat=%0d", sd, a, b, result == 64'd0 ? exp_res : result, lat);
    endtask

    initial begin
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        total = 0;
        bad = 0;
        reset = 1'b1;
        signed_div = 1'b0;
        dividend = 32'd0;
        divisor = 32'd0;
        start = 1'b0;
        annul = 1'b0;
        tick();
        tick();
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_stop_req", 64'(stop_req), 64'd0);
        reset = 1'b0;
        tick();

        run_div(1'b0, 32'd100, 32'd7, 2);
        check("unsigned_100_7", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 1);
        run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 1);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1);
        run_div(1'b0, 32'hFFFFFFFF, 32'h00000001, 1);
        run_div(1'b0, 32'h12345678, 32'h00000000, 1);
        run_div(1'b1, 32'h12345678, 32'h00000000, 0);

        // Annul at iteration 10 with start held through it.
        signed_div = 1'b0;
        dividend = 32'd1000;
        divisor = 32'd7;
        start = 1'b1;
        tick();
        repeat (10) tick();
        annul = 1'b1;
        tick();
        annul = 1'b0;
        start = 1'b0;
        check("annul_ready", 64'(ready), 64'd0);
        check("annul_result", result, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("annul_idle_ready", 64'(ready), 64'd0);
            check("annul_idle_result", result, 64'd0);
        end
        $display("annul at iteration 10 ready=%0d result=%h", ready, result);
        run_div(1'b0, 32'd9, 32'd3, 0);

        // Annul coinciding with the final (result-latching) cycle.
        signed_div = 1'b0;
        dividend = 32'd50;
        divisor = 32'd5;
        start = 1'b1;
        tick();
        repeat (32) tick();
        check("pre_final_ready", 64'(ready), 64'd0);
        annul = 1'b1;
        tick();
        annul = 1'b0;
        start = 1'b0;
        check("annul_final_ready", 64'(ready), 64'd0);
        check("annul_final_result", result, 64'd0);
        tick();
        check("annul_final_idle", 64'(ready), 64'd0);
        $display("annul at final cycle ready=%0d result=%h", ready, result);

        // Annul together with start in FREE must not launch the operation.
        signed_div = 1'b0;
        dividend = 32'd77;
        divisor = 32'd4;
        start = 1'b1;
        annul = 1'b1;
        tick();
        annul = 1'b0;
        check("annul_free_ready", 64'(ready), 64'd0);
        $display("annul with start in free ready=%0d", ready);
        run_div(1'b0, 32'd77, 32'd4, 0);

        // Reset mid-operation.
        signed_div = 1'b1;
        dividend = 32'hDEADBEEF;
        divisor = 32'd13;
        start = 1'b1;
        tick();
        repeat (15) tick();
        reset = 1'b1;
        tick();
        check("midreset_ready", 64'(ready), 64'd0);
        check("midreset_result", result, 64'd0);
        check("midreset_stop_req", 64'(stop_req), 64'd1);
        $display("reset mid-operation ready=%0d result=%h", ready, result);
        reset = 1'b0;
        start = 1'b0;
        tick();
        run_div(1'b1, 32'hFFFFFF00, 32'd16, 0);

        for (int n = 0; n < 16; n++) begin
            sd = 1'($urandom);
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 100);
                1: a = 32'h80000000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_div(sd, a, b, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
